// File: rtl/score_disp_pkg.sv
// Shared types and segment constants for the score display driver.
package score_disp_pkg;

  typedef enum logic [1:0] {
    DIG_ONES = 2'd0,
    DIG_TENS = 2'd1,
    DIG_HUND = 2'd2
  } slot_state_t;

  // Segment order {g,f,e,d,c,b,a}, active-high
  localparam logic [6:0] SEG_DIGITS [0:9] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
    7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F
  };
  localparam logic [6:0] SEG_DASH = 7'h40;
  localparam logic [6:0] SEG_OFF  = 7'h00;

endpackage

// File: rtl/bcd_to_seg7.sv
// BCD digit to seven-segment pattern; non-decimal codes render as a dash.
module bcd_to_seg7
  import score_disp_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_DASH;
    if (bcd <= 4'd9) seg = SEG_DIGITS[bcd];
  end

endmodule

// File: rtl/score_display_driver.sv
// Three-digit multiplexed seven-segment driver with frame snapshot,
// leading-zero blanking, anti-ghost guard and game-over blinking.
module score_display_driver
  import score_disp_pkg::*;
#(
  parameter int SCAN_DIV     = 1000,
  parameter int GUARD        = 2,
  parameter int BLINK_FRAMES = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] bcd_ones,
  input  logic [3:0] bcd_tens,
  input  logic [3:0] bcd_hundreds,
  input  logic       isGameComplete,
  output logic [6:0] seg,
  output logic [2:0] digit_en
);

  localparam logic [15:0] SCAN_LAST  = 16'(SCAN_DIV - 1);
  localparam logic [15:0] GUARD_LEN  = 16'(GUARD);
  localparam logic [7:0]  FRAME_LAST = 8'(BLINK_FRAMES - 1);

  slot_state_t state;
  logic [15:0] scan_cnt;
  logic [7:0]  frame_cnt;
  logic        blink_on;
  logic [3:0]  sh_ones, sh_tens, sh_hund;
  logic        sh_complete;

  logic        scan_wrap, frame_end;
  logic [3:0]  slot_digit;
  logic [2:0]  slot_en;
  logic        slot_blank, slot_active;
  logic [6:0]  slot_seg;

  assign scan_wrap = (scan_cnt == SCAN_LAST);
  assign frame_end = scan_wrap && (state == DIG_HUND);

  always_comb begin
    slot_digit = sh_ones;
    slot_en    = 3'b001;
    slot_blank = 1'b0;
    case (state)
      DIG_TENS: begin
        slot_digit = sh_tens;
        slot_en    = 3'b010;
        slot_blank = (sh_hund == 4'd0) && (sh_tens == 4'd0);
      end
      DIG_HUND: begin
        slot_digit = sh_hund;
        slot_en    = 3'b100;
        slot_blank = (sh_hund == 4'd0);
      end
      default: ;
    endcase
    slot_active = (scan_cnt >= GUARD_LEN) && !slot_blank && blink_on;
  end

  bcd_to_seg7 u_dec (
    .bcd (slot_digit),
    .seg (slot_seg)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= DIG_ONES;
      scan_cnt    <= 16'd0;
      frame_cnt   <= 8'd0;
      blink_on    <= 1'b1;
      sh_ones     <= 4'd0;
      sh_tens     <= 4'd0;
      sh_hund     <= 4'd0;
      sh_complete <= 1'b0;
      seg         <= SEG_OFF;
      digit_en    <= 3'b000;
    end else begin
      scan_cnt <= scan_wrap ? 16'd0 : scan_cnt + 16'd1;
      if (scan_wrap) begin
        case (state)
          DIG_ONES: state <= DIG_TENS;
          DIG_TENS: state <= DIG_HUND;
          default:  state <= DIG_ONES;
        endcase
      end

      // Snapshot once per frame so a digit never changes mid-scan
      if (frame_end) begin
        sh_ones     <= bcd_ones;
        sh_tens     <= bcd_tens;
        sh_hund     <= bcd_hundreds;
        sh_complete <= isGameComplete;
        if (!isGameComplete) begin
          frame_cnt <= 8'd0;
          blink_on  <= 1'b1;
        end else if (frame_cnt == FRAME_LAST) begin
          frame_cnt <= 8'd0;
          blink_on  <= ~blink_on;
        end else begin
          frame_cnt <= frame_cnt + 8'd1;
        end
      end

      seg      <= slot_active ? slot_seg : SEG_OFF;
      digit_en <= slot_active ? slot_en  : 3'b000;
    end
  end

endmodule

// File: doc/score_display_driver.md
Name: score_display_driver

Overview:
- Downstream consumer of the score tracker. Takes its registered BCD digits (ones/tens/hundreds) and game-complete flag, and drives a 3-digit multiplexed common-cathode seven-segment display.
- Features: scan-rate time multiplexing, anti-ghosting guard interval, leading-zero blanking, tear-free frame snapshot of the digits, and blinking of the final high score while the game is complete.

Parameters:
- SCAN_DIV, 1000, clock cycles each digit slot lasts (>= GUARD+1, <= 65535)
- GUARD, 2, cycles at the start of each slot with all digits disabled (anti-ghost), < SCAN_DIV
- BLINK_FRAMES, 64, full scan frames per blink half-period while game complete (>= 1, <= 255)

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- bcd_ones  in  4  score ones digit from score tracker
- bcd_tens  in  4  score tens digit
- bcd_hundreds  in  4  score hundreds digit
- isGameComplete  in  1  game over; display shows high score, blinking
- seg  out  7  segments {g,f,e,d,c,b,a}, bit0=a, active-high
- digit_en  out  3  one-hot digit enable; bit0=ones, bit1=tens, bit2=hundreds; active-high

Behaviour:
- One clock (clk); reset is synchronous and active-high (rst). All state changes on posedge clk; rst has priority over all other logic.
- Reset values: seg=0, digit_en=0, scan_cnt=0, slot state=DIG_ONES, shadow digits=0, shadow complete=0, frame_cnt=0, blink_on=1.
- scan_cnt counts 0..SCAN_DIV-1 and then wraps to 0. On wrap, the slot FSM advances DIG_ONES -> DIG_TENS -> DIG_HUND -> DIG_ONES. No other transitions.
- Frame end: the cycle with state==DIG_HUND and scan_cnt==SCAN_DIV-1. At that cycle:
  - the shadow registers load bcd_ones/tens/hundreds and isGameComplete;
  - the blink logic updates.
- Input changes mid-frame are invisible until the next frame end. Worst-case display latency is 3*SCAN_DIV+1 cycles.
- Blink logic at frame end:
  - If the newly sampled complete flag is 0: frame_cnt=0 and blink_on=1.
  - Otherwise frame_cnt increments. When frame_cnt reaches BLINK_FRAMES-1, it wraps to 0 and blink_on toggles.
- Digit decode: values 0-9 use the standard 7-seg patterns (0=7'h3F, 1=7'h06, ... 8=7'h7F, 9=7'h6F). Any value >9 shows a dash (7'h40).
- Leading-zero blanking:
  - hundreds slot is blank when shadow hundreds==0;
  - tens slot is blank when shadow hundreds==0 and tens==0;
  - ones is never blanked.
  - Dash digits are never blanked.
- Slot outputs:
  - Active slot: digit_en = the one-hot bit of the current slot, seg = the decoded pattern.
  - A slot is inactive when scan_cnt<GUARD, the slot is blanked, or blink_on==0. An inactive slot drives digit_en=0 and seg=0.
- Outputs are registered: seg/digit_en at cycle t reflect the state at cycle t-1. The first cycle after rst deasserts still shows zeros.
- Reset mid-frame: the display goes dark the next cycle and the snapshot is discarded. The restart begins at DIG_ONES, showing "0" on ones after GUARD+1 cycles.
- Simultaneous isGameComplete rise and digit change at frame end: both are captured in the same snapshot.
- Arithmetic: scan_cnt is 16 bits and frame_cnt is 8 bits, compared with equality only. No overflow is possible within the parameter ranges.

Decomposition:
- Package score_disp_pkg holds:
  - slot_state_t enum {DIG_ONES, DIG_TENS, DIG_HUND};
  - SEG_DIGITS[0:9] constant array;
  - SEG_DASH = 7'h40;
  - SEG_OFF = 7'h00.
- One combinational sub-module bcd_to_seg7 (4-bit in, 7-bit out, dash for >9), instantiated once on the muxed slot digit.
- Top level holds the counters, FSM, shadow registers, blink logic and output registers.

Test Plan:
- rst held 5 cycles then released, inputs 0, SCAN_DIV=4, GUARD=1 -> seg=0/digit_en=0 through the first post-reset cycle. Then on each ones slot digit_en=001 and seg=7'h3F for 3 cycles; tens and hundreds slots stay dark.
- Inputs 1/2/3 (hundreds/tens/ones) applied mid-frame -> the old value persists until frame end. The next frame shows ones 7'h4F, tens 7'h5B, hundreds 7'h06 on digit_en 001/010/100, with 1 dark guard cycle each.
- Score 7 then 40 -> 7: only ones is lit. 40: tens=7'h66 lit, ones=7'h3F lit, hundreds dark.
- bcd_tens=4'hC injected -> the tens slot shows 7'h40, even when hundreds==0.
- isGameComplete=1 with score 140, BLINK_FRAMES=2 -> the display is lit for 2 frames, dark (digit_en=0) for 2 frames, and repeats. Deasserting it restores steady display from the next frame.
- rst asserted at scan_cnt=2 in DIG_TENS -> seg/digit_en=0 the next cycle. After release, the FSM restarts at DIG_ONES with scan_cnt=0 and shows "0".
